ahbl_arb2: RTL and testbench
============================

AHBL_ARB2 -- requirements
Module: ahbl_arb2

Interface
REQ-001 SHALL have parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority with M0 highest.
REQ-002 SHALL have port HCLK, input, 1: single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port HRESETn, input, 1: asynchronous active-low reset.
REQ-004 SHALL have ports M<n>_HADDR, input, 32, n=0,1: master n address (M0 = CPU, M1 = DMAC).
REQ-005 SHALL have ports M<n>_HTRANS, input, 2: master n transfer type.
REQ-006 SHALL have ports M<n>_HSIZE, input, 3: master n transfer size.
REQ-007 SHALL have ports M<n>_HWRITE, input, 1: master n write.
REQ-008 SHALL have ports M<n>_HWDATA, input, 32: master n write data, valid in its data phase.
REQ-009 SHALL have ports M<n>_HREADY, output, 1: ready returned to master n.
REQ-010 SHALL have ports M<n>_HRDATA, output, 32: read data returned to master n.
REQ-011 SHALL have ports S_HADDR, output, 32; S_HTRANS, output, 2; S_HSIZE, output, 3; S_HWRITE, output, 1: slave address phase.
REQ-012 SHALL have port S_HWDATA, output, 32: slave write data.
REQ-013 SHALL have port S_HREADY, output, 1: bus ready to slave, equal to S_HREADYOUT.
REQ-014 SHALL have ports S_HREADYOUT, input, 1, and S_HRDATA, input, 32: slave ready and read data.

Function
REQ-015 SHALL treat master n as presenting a request when M<n>_HTRANS[1]=1 and M<n>_HREADY=1 (accepted address phase).
REQ-016 SHALL, in any cycle with S_HREADYOUT=1, grant at most one master among {pend_valid[n] OR live request n}.
REQ-017 SHALL take a granted master's attributes from its pending register when pend_valid[n]=1, else from its live inputs (zero-latency bypass).
REQ-018 SHALL drive S_HTRANS=2'b10 (NONSEQ) for every grant, converting SEQ to NONSEQ; 2'b00 (IDLE) with no grant.
REQ-019 SHALL capture an accepted but ungranted request into master n's pending register (HADDR, HSIZE, HWRITE) and set pend_valid[n] on the next edge.
REQ-020 SHALL clear pend_valid[n] on the edge at which its grant is accepted (S_HREADYOUT=1).
REQ-021 SHALL register dp_valid and dp_owner on every edge with S_HREADYOUT=1: dp_valid=grant present, dp_owner=granted index.
REQ-022 SHALL drive S_HWDATA=M<dp_owner>_HWDATA; SHALL drive S_HRDATA to both M<n>_HRDATA unconditionally.
REQ-023 SHALL drive M<n>_HREADY = S_HREADYOUT when dp_valid and dp_owner=n; else 0 when pend_valid[n] or master n was granted this cycle from pending; else 1.
REQ-024 SHALL, with RR=1, give priority to the master not granted last (last_grant register updated on each accepted grant); with RR=0, always M0 first.
REQ-025 SHALL, on simultaneous requests with S_HREADYOUT=0, grant neither and pend both live requests.
REQ-026 SHALL never hold more than one outstanding transfer per master; pend_valid[n] and (dp_valid, dp_owner=n) SHALL never both be set.
REQ-027 SHALL ignore IDLE/BUSY (HTRANS[1]=0) master cycles entirely.

Reset
REQ-028 SHALL, on HRESETn=0, asynchronously clear pend_valid, dp_valid, dp_owner=0, and set last_grant=1 so M0 wins first; all pending attributes cleared to 0.
REQ-029 SHALL, during and immediately after reset, output M<n>_HREADY=1, S_HTRANS=IDLE, S_HREADY=S_HREADYOUT; in-flight transfers are discarded.

Structure
REQ-030 SHALL place HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and master index constants in shared package ahbl_pkg.
REQ-031 SHALL instantiate sub-module ahbl_arb_in_stage twice, one per master, holding pending register and live/pending select; arbitration and data-phase tracking stay in top level.

Verification
REQ-032 SHALL cover: M0 word write 0x0000_0010=0xDEADBEEF alone -> S_HTRANS=NONSEQ same cycle, M0_HREADY high, RAM word updated, no pending.
REQ-033 SHALL cover: M0 and M1 NONSEQ reads same cycle, RR=1, after reset -> M0 granted first, M1 pended one cycle, M1_HREADY low one extra cycle, both receive correct data.
REQ-034 SHALL cover: 4-beat SEQ burst from M1 interleaved with M0 singles -> slave sees only NONSEQ, alternating owners, data routed by dp_owner.
REQ-035 SHALL cover: RR=0, both masters continuously requesting 8 transfers -> M0 served every grant, M1 served only when M0 idle.
REQ-036 SHALL cover: S_HREADYOUT forced low 3 cycles with both requests -> no grant, both pended, order resumes M0 then M1.
REQ-037 SHALL cover: HRESETn asserted with M1 pending -> pend_valid=0, M1_HREADY=1, S_HTRANS=IDLE next cycle.

Source files
------------

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, master indices and the address-phase attribute
// bundle used by the two-master arbiter.
package ahbl_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam int   NUM_MST = 2;
    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DMA = 1'b1;

    typedef struct packed {
        logic [31:0] haddr;
        logic [2:0]  hsize;
        logic        hwrite;
    } ahb_addr_t;

    // IDLE and BUSY carry no address phase; only NONSEQ/SEQ are requests.
    function automatic logic htrans_active(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahbl_arb_in_stage.sv
// Per-master input stage: holds an accepted-but-ungranted address phase and
// presents either that pending phase or the live bus to the arbiter.
import ahbl_pkg::*;

module ahbl_arb_in_stage (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  ahb_addr_t  live_i,
    input  logic [1:0] htrans_i,
    input  logic       hready_i,
    input  logic       grant_i,
    output logic       req_o,
    output logic       pend_valid_o,
    output ahb_addr_t  attr_o
);

    logic      live_req;
    logic      pend_valid_q, pend_valid_d;
    ahb_addr_t pend_q, pend_d;

    assign live_req = htrans_active(htrans_i) && hready_i;

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        if (grant_i) begin
            pend_valid_d = 1'b0;
        end else if (live_req) begin
            pend_valid_d = 1'b1;
            pend_d       = live_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
        end
    end

    // A pending master sees HREADY low, so it never has a live request too.
    assign req_o        = pend_valid_q || live_req;
    assign pend_valid_o = pend_valid_q;
    assign attr_o       = pend_valid_q ? pend_q : live_i;

endmodule

// File: rtl/ahbl_arb2.sv
// Two-master AHB-Lite arbiter (CPU on M0, DMAC on M1) onto a single slave,
// with zero-latency bypass, per-master pending slot and round-robin option.
import ahbl_pkg::*;

module ahbl_arb2 #(
    parameter int RR = 1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] M0_HADDR,
    input  logic [1:0]  M0_HTRANS,
    input  logic [2:0]  M0_HSIZE,
    input  logic        M0_HWRITE,
    input  logic [31:0] M0_HWDATA,
    output logic        M0_HREADY,
    output logic [31:0] M0_HRDATA,
    input  logic [31:0] M1_HADDR,
    input  logic [1:0]  M1_HTRANS,
    input  logic [2:0]  M1_HSIZE,
    input  logic        M1_HWRITE,
    input  logic [31:0] M1_HWDATA,
    output logic        M1_HREADY,
    output logic [31:0] M1_HRDATA,
    output logic [31:0] S_HADDR,
    output logic [1:0]  S_HTRANS,
    output logic [2:0]  S_HSIZE,
    output logic        S_HWRITE,
    output logic [31:0] S_HWDATA,
    output logic        S_HREADY,
    input  logic        S_HREADYOUT,
    input  logic [31:0] S_HRDATA
);

    ahb_addr_t [NUM_MST-1:0]        live, attr;
    logic      [NUM_MST-1:0][1:0]   htrans;
    logic      [NUM_MST-1:0][31:0]  hwdata;
    logic      [NUM_MST-1:0]        hready, req, pend_valid, grant;
    logic pri, gidx, grant_any;
    logic dp_valid_q, dp_valid_d, dp_owner_q, dp_owner_d, last_grant_q, last_grant_d;

    assign live[0]   = '{haddr: M0_HADDR, hsize: M0_HSIZE, hwrite: M0_HWRITE};
    assign live[1]   = '{haddr: M1_HADDR, hsize: M1_HSIZE, hwrite: M1_HWRITE};
    assign htrans[0] = M0_HTRANS;
    assign htrans[1] = M1_HTRANS;
    assign hwdata[0] = M0_HWDATA;
    assign hwdata[1] = M1_HWDATA;

    for (genvar i = 0; i < NUM_MST; i++) begin : g_in
        ahbl_arb_in_stage u_in (
            .clk_i        (HCLK),
            .rst_ni       (HRESETn),
            .live_i       (live[i]),
            .htrans_i     (htrans[i]),
            .hready_i     (hready[i]),
            .grant_i      (grant[i]),
            .req_o        (req[i]),
            .pend_valid_o (pend_valid[i]),
            .attr_o       (attr[i])
        );
        // A master granted from pending is still pending this cycle, so
        // ~pend_valid already covers that case.
        assign hready[i] = (dp_valid_q && dp_owner_q == 1'(i)) ? S_HREADYOUT : ~pend_valid[i];
    end

    always_comb begin
        pri   = (RR != 0) ? ~last_grant_q : MST_CPU;
        grant = '0;
        gidx  = MST_CPU;
        if (HRESETn && S_HREADYOUT) begin
            if (req[pri]) begin
                grant[pri] = 1'b1;
                gidx       = pri;
            end else if (req[~pri]) begin
                grant[~pri] = 1'b1;
                gidx        = ~pri;
            end
        end
    end

    assign grant_any = |grant;

    always_comb begin
        dp_valid_d   = dp_valid_q;
        dp_owner_d   = dp_owner_q;
        last_grant_d = last_grant_q;
        if (S_HREADYOUT) begin
            dp_valid_d = grant_any;
            if (grant_any) begin
                dp_owner_d   = gidx;
                last_grant_d = gidx;
            end
        end
    end

    // last_grant resets to M1 so the first round-robin decision favours M0.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid_q   <= 1'b0;
            dp_owner_q   <= MST_CPU;
            last_grant_q <= MST_DMA;
        end else begin
            dp_valid_q   <= dp_valid_d;
            dp_owner_q   <= dp_owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign S_HADDR   = attr[gidx].haddr;
    assign S_HSIZE   = attr[gidx].hsize;
    assign S_HWRITE  = attr[gidx].hwrite;
    assign S_HTRANS  = grant_any ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign S_HWDATA  = hwdata[dp_owner_q];
    assign S_HREADY  = S_HREADYOUT;
    assign M0_HREADY = hready[0];
    assign M1_HREADY = hready[1];
    assign M0_HRDATA = S_HRDATA;
    assign M1_HRDATA = S_HRDATA;

endmodule

// File: tb/tb_ahbl_arb2.sv
// Directed bench for ahbl_arb2: round-robin instance drives a small RAM model,
// a fixed-priority instance shares the master inputs for the priority test.
module tb_ahbl_arb2;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA;
    logic [1:0]  M0_HTRANS, M1_HTRANS;
    logic [2:0]  M0_HSIZE, M1_HSIZE;
    logic        M0_HWRITE, M1_HWRITE;
    logic        S_HREADYOUT;
    logic [31:0] S_HRDATA;

    logic        M0_HREADY, M1_HREADY, S_HWRITE, S_HREADY;
    logic [31:0] M0_HRDATA, M1_HRDATA, S_HADDR, S_HWDATA;
    logic [1:0]  S_HTRANS;
    logic [2:0]  S_HSIZE;

    logic        f_M0_HREADY, f_M1_HREADY, f_S_HWRITE, f_S_HREADY;
    logic [31:0] f_M0_HRDATA, f_M1_HRDATA, f_S_HADDR, f_S_HWDATA;
    logic [1:0]  f_S_HTRANS;
    logic [2:0]  f_S_HSIZE;

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    ahbl_arb2 #(.RR(1)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
        .M0_HWDATA(M0_HWDATA), .M0_HREADY(M0_HREADY), .M0_HRDATA(M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
        .M1_HWDATA(M1_HWDATA), .M1_HREADY(M1_HREADY), .M1_HRDATA(M1_HRDATA),
        .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE), .S_HWRITE(S_HWRITE),
        .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA)
    );

    ahbl_arb2 #(.RR(0)) u_fix (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HSIZE(M0_HSIZE), .M0_HWRITE(M0_HWRITE),
        .M0_HWDATA(M0_HWDATA), .M0_HREADY(f_M0_HREADY), .M0_HRDATA(f_M0_HRDATA),
        .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HSIZE(M1_HSIZE), .M1_HWRITE(M1_HWRITE),
        .M1_HWDATA(M1_HWDATA), .M1_HREADY(f_M1_HREADY), .M1_HRDATA(f_M1_HRDATA),
        .S_HADDR(f_S_HADDR), .S_HTRANS(f_S_HTRANS), .S_HSIZE(f_S_HSIZE), .S_HWRITE(f_S_HWRITE),
        .S_HWDATA(f_S_HWDATA), .S_HREADY(f_S_HREADY), .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA)
    );

    // Zero-wait RAM slave; each word resets to C0DE_0000 + word index.
    logic [31:0] mem [0:255];
    logic        sdp_v, sdp_w;
    logic [7:0]  sdp_i;

    always @(posedge HCLK) begin
        if (!HRESETn) begin
            for (int k = 0; k < 256; k++) mem[k] <= 32'hC0DE_0000 | 32'(k);
            sdp_v <= 1'b0;
            sdp_w <= 1'b0;
            sdp_i <= 8'd0;
        end else if (S_HREADYOUT) begin
            if (sdp_v && sdp_w) mem[sdp_i] <= S_HWDATA;
            sdp_v <= S_HTRANS[1];
            sdp_w <= S_HWRITE;
            sdp_i <= S_HADDR[9:2];
        end
    end

    assign S_HRDATA = mem[sdp_i];

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic m0(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] d);
        M0_HTRANS = t; M0_HADDR = a; M0_HWRITE = w; M0_HWDATA = d; M0_HSIZE = 3'b010;
    endtask

    task automatic m1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [31:0] d);
        M1_HTRANS = t; M1_HADDR = a; M1_HWRITE = w; M1_HWDATA = d; M1_HSIZE = 3'b010;
    endtask

    task automatic apply_reset();
        step();
        HRESETn = 1'b0;
        S_HREADYOUT = 1'b1;
        m0(2'b00, 32'h0, 1'b0, 32'h0);
        m1(2'b00, 32'h0, 1'b0, 32'h0);
        repeat (3) step();
        HRESETn = 1'b1;
    endtask

    task automatic test_reset();
        // M0 drives NONSEQ throughout reset; nothing may reach the slave.
        repeat (3) step();
        #2;
        total++; if (S_HTRANS !== 2'b00) begin bad++; $display("FAIL rst_htrans got=%h exp=0", S_HTRANS); end
        total++; if (M0_HREADY !== 1'b1) begin bad++; $display("FAIL rst_m0_hready got=%b exp=1", M0_HREADY); end
        total++; if (M1_HREADY !== 1'b1) begin bad++; $display("FAIL rst_m1_hready got=%b exp=1", M1_HREADY); end
        S_HREADYOUT = 1'b0;
        #1;
        total++; if (S_HREADY !== 1'b0) begin bad++; $display("FAIL rst_s_hready got=%b exp=0", S_HREADY); end
        S_HREADYOUT = 1'b1;
        m0(2'b00, 32'h0, 1'b0, 32'h0);
        HRESETn = 1'b1;
        step(); #2;
        total++; if (S_HTRANS !== 2'b00) begin bad++; $display("FAIL rst_after_htrans got=%h exp=0", S_HTRANS); end
        total++; if (M0_HREADY !== 1'b1) begin bad++; $display("FAIL rst_after_m0_hready got=%b exp=1", M0_HREADY); end
    endtask

    task automatic test_single_write();
        step(); m0(2'b10, 32'h0000_0010, 1'b1, 32'h0); #2;
        total++; if (S_HTRANS !== 2'b10) begin bad++; $display("FAIL wr_htrans got=%h exp=2", S_HTRANS); end
        total++; if (S_HADDR !== 32'h10) begin bad++; $display("FAIL wr_haddr got=%h exp=10", S_HADDR); end
        total++; if (S_HWRITE !== 1'b1 || S_HSIZE !== 3'b010) begin bad++; $display("FAIL wr_attr got=%b/%h exp=1/2", S_HWRITE, S_HSIZE); end
        total++; if (M0_HREADY !== 1'b1) begin bad++; $display("FAIL wr_m0_hready_a got=%b exp=1", M0_HREADY); end
        step(); m0(2'b00, 32'h0, 1'b0, 32'hDEAD_BEEF); #2;
        total++; if (M0_HREADY !== 1'b1) begin bad++; $display("FAIL wr_m0_hready_d got=%b exp=1", M0_HREADY); end
        total++; if (S_HWDATA !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_hwdata got=%h exp=deadbeef", S_HWDATA); end
        total++; if (S_HTRANS !== 2'b00) begin bad++; $display("FAIL wr_idle got=%h exp=0", S_HTRANS); end
        total++; if (M1_HREADY !== 1'b1) begin bad++; $display("FAIL wr_m1_hready got=%b exp=1", M1_HREADY); end
        step(); #2;
        total++; if (mem[4] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL wr_ram got=%h exp=deadbeef", mem[4]); end
    endtask

    task automatic test_both_reads();
        apply_reset();
        step(); m0(2'b10, 32'h20, 1'b0, 32'h0); m1(2'b10, 32'h24, 1'b0, 32'h0); #2;
        total++; if (S_HADDR !== 32'h20 || S_HTRANS !== 2'b10) begin bad++; $display("FAIL both_c0 got=%h/%h exp=20/2", S_HADDR, S_HTRANS); end
        step(); m0(2'b00, 32'h0, 1'b0, 32'h0); m1(2'b00, 32'h0, 1'b0, 32'h0); #2;
        total++; if (S_HADDR !== 32'h24 || S_HTRANS !== 2'b10) begin bad++; $display("FAIL both_c1 got=%h/%h exp=24/2", S_HADDR, S_HTRANS); end
        total++; if (M1_HREADY !== 1'b0) begin bad++; $display("FAIL both_m1_wait got=%b exp=0", M1_HREADY); end
        total++; if (M0_HREADY !== 1'b1 || M0_HRDATA !== 32'hC0DE_0008) begin bad++; $display("FAIL both_m0_data got=%b/%h exp=1/c0de0008", M0_HREADY, M0_HRDATA); end
        step(); #2;
        total++; if (M1_HREADY !== 1'b1 || M1_HRDATA !== 32'hC0DE_0009) begin bad++; $display("FAIL both_m1_data got=%b/%h exp=1/c0de0009", M1_HREADY, M1_HRDATA); end
        total++; if (S_HTRANS !== 2'b00) begin bad++; $display("FAIL both_idle got=%h exp=0", S_HTRANS); end
    endtask

    // Per-cycle stimulus and hand-derived expectations for the burst interleave.
    localparam logic [1:0]  B_M0_T [7] = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [31:0] B_M0_A [7] = '{32'h80, 32'h84, 32'h84, 32'h84, 32'h84, 32'h84, 32'h84};
    localparam logic [31:0] B_M0_D [7] = '{32'h0, 32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0001,
                                          32'hAAAA_0001, 32'hAAAA_0001, 32'hAAAA_0001};
    localparam logic [1:0]  B_M1_T [7] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    localparam logic [31:0] B_M1_A [7] = '{32'h40, 32'h44, 32'h44, 32'h48, 32'h48, 32'h4C, 32'h4C};
    localparam logic [31:0] B_M1_D [7] = '{32'h0, 32'h1111_0000, 32'h1111_0000, 32'h1111_0001,
                                          32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
    localparam logic [1:0]  B_EXP_T [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
    localparam logic [31:0] B_EXP_A [7] = '{32'h80, 32'h40, 32'h84, 32'h44, 32'h48, 32'h4C, 32'h0};
    localparam logic [31:0] B_EXP_D [7] = '{32'h0, 32'hAAAA_0000, 32'h1111_0000, 32'hAAAA_0001,
                                           32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
    localparam logic [6:0]  B_EXP_R0 = 7'b1111011;
    localparam logic [6:0]  B_EXP_R1 = 7'b1110101;

    task automatic test_burst_interleave();
        logic [6:0] r0, r1;
        logic [31:0] exp_mem [6];
        logic [7:0]  idx_mem [6];
        r0 = B_EXP_R0;
        r1 = B_EXP_R1;
        for (int c = 0; c < 7; c++) begin
            step();
            m0(B_M0_T[c], B_M0_A[c], 1'b1, B_M0_D[c]);
            m1(B_M1_T[c], B_M1_A[c], 1'b1, B_M1_D[c]);
            #2;
            total++; if (S_HTRANS !== B_EXP_T[c]) begin bad++; $display("FAIL burst_htrans c%0d got=%h exp=%h", c, S_HTRANS, B_EXP_T[c]); end
            if (B_EXP_T[c] == 2'b10) begin
                total++; if (S_HADDR !== B_EXP_A[c]) begin bad++; $display("FAIL burst_haddr c%0d got=%h exp=%h", c, S_HADDR, B_EXP_A[c]); end
            end
            if (c > 0) begin
                total++; if (S_HWDATA !== B_EXP_D[c]) begin bad++; $display("FAIL burst_hwdata c%0d got=%h exp=%h", c, S_HWDATA, B_EXP_D[c]); end
            end
            total++; if (M0_HREADY !== r0[c] || M1_HREADY !== r1[c]) begin bad++; $display("FAIL burst_hready c%0d got=%b%b exp=%b%b", c, M0_HREADY, M1_HREADY, r0[c], r1[c]); end
        end
        step(); m0(2'b00, 32'h0, 1'b0, 32'h0); m1(2'b00, 32'h0, 1'b0, 32'h0); #2;
        idx_mem = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21};
        exp_mem = '{32'h1111_0000, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'hAAAA_0000, 32'hAAAA_0001};
        for (int k = 0; k < 6; k++) begin
            total++; if (mem[idx_mem[k]] !== exp_mem[k]) begin bad++; $display("FAIL burst_ram idx=%h got=%h exp=%h", idx_mem[k], mem[idx_mem[k]], exp_mem[k]); end
        end
    endtask

    task automatic test_fixed_priority();
        logic [31:0] ea;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            step();
            m0(2'b10, 32'h100 + 32'(4 * k), 1'b0, 32'h0);
            m1(2'b10, (k == 0) ? 32'h200 : 32'h204, 1'b0, 32'h0);
            #2;
            ea = 32'h100 + 32'(4 * k);
            total++; if (f_S_HTRANS !== 2'b10 || f_S_HADDR !== ea) begin bad++; $display("FAIL fix_m0 k%0d got=%h/%h exp=2/%h", k, f_S_HTRANS, f_S_HADDR, ea); end
            total++; if (f_M1_HREADY !== (k == 0)) begin bad++; $display("FAIL fix_m1_hready k%0d got=%b", k, f_M1_HREADY); end
        end
        for (int j = 0; j < 4; j++) begin
            step();
            m0(2'b00, 32'h0, 1'b0, 32'h0);
            m1(2'b10, (j == 0) ? 32'h204 : 32'h200 + 32'(4 * j), 1'b0, 32'h0);
            #2;
            ea = 32'h200 + 32'(4 * j);
            total++; if (f_S_HTRANS !== 2'b10 || f_S_HADDR !== ea) begin bad++; $display("FAIL fix_m1 j%0d got=%h/%h exp=2/%h", j, f_S_HTRANS, f_S_HADDR, ea); end
        end
        step(); m1(2'b00, 32'h0, 1'b0, 32'h0); #2;
        total++; if (f_S_HTRANS !== 2'b00) begin bad++; $display("FAIL fix_idle got=%h exp=0", f_S_HTRANS); end
    endtask

    task automatic test_stall();
        apply_reset();
        step(); S_HREADYOUT = 1'b0;
        m0(2'b10, 32'h20, 1'b0, 32'h0); m1(2'b10, 32'h24, 1'b0, 32'h0); #2;
        total++; if (S_HTRANS !== 2'b00 || S_HREADY !== 1'b0) begin bad++; $display("FAIL stall_c0 got=%h/%b exp=0/0", S_HTRANS, S_HREADY); end
        for (int c = 1; c < 3; c++) begin
            step(); m0(2'b00, 32'h0, 1'b0, 32'h0); m1(2'b00, 32'h0, 1'b0, 32'h0); #2;
            total++; if (S_HTRANS !== 2'b00) begin bad++; $display("FAIL stall_idle c%0d got=%h exp=0", c, S_HTRANS); end
            total++; if (M0_HREADY !== 1'b0 || M1_HREADY !== 1'b0) begin bad++; $display("FAIL stall_pend c%0d got=%b%b exp=00", c, M0_HREADY, M1_HREADY); end
        end
        step(); S_HREADYOUT = 1'b1; #2;
        total++; if (S_HTRANS !== 2'b10 || S_HADDR !== 32'h20) begin bad++; $display("FAIL stall_g0 got=%h/%h exp=2/20", S_HTRANS, S_HADDR); end
        step(); #2;
        total++; if (S_HTRANS !== 2'b10 || S_HADDR !== 32'h24) begin bad++; $display("FAIL stall_g1 got=%h/%h exp=2/24", S_HTRANS, S_HADDR); end
        total++; if (M0_HREADY !== 1'b1 || M0_HRDATA !== 32'hC0DE_0008) begin bad++; $display("FAIL stall_d0 got=%b/%h exp=1/c0de0008", M0_HREADY, M0_HRDATA); end
        total++; if (M1_HREADY !== 1'b0) begin bad++; $display("FAIL stall_m1_wait got=%b exp=0", M1_HREADY); end
        step(); #2;
        total++; if (M1_HREADY !== 1'b1 || M1_HRDATA !== 32'hC0DE_0009) begin bad++; $display("FAIL stall_d1 got=%b/%h exp=1/c0de0009", M1_HREADY, M1_HRDATA); end
    endtask

    task automatic test_reset_pending();
        step(); m0(2'b10, 32'h30, 1'b0, 32'h0); m1(2'b10, 32'h34, 1'b0, 32'h0); #2;
        total++; if (S_HADDR !== 32'h30) begin bad++; $display("FAIL rp_m0 got=%h exp=30", S_HADDR); end
        step(); m0(2'b00, 32'h0, 1'b0, 32'h0); m1(2'b00, 32'h0, 1'b0, 32'h0); #2;
        total++; if (M1_HREADY !== 1'b0) begin bad++; $display("FAIL rp_pending got=%b exp=0", M1_HREADY); end
        HRESETn = 1'b0;
        #1;
        total++; if (M1_HREADY !== 1'b1 || S_HTRANS !== 2'b00) begin bad++; $display("FAIL rp_async got=%b/%h exp=1/0", M1_HREADY, S_HTRANS); end
        step(); HRESETn = 1'b1; #2;
        total++; if (M1_HREADY !== 1'b1 || S_HTRANS !== 2'b00) begin bad++; $display("FAIL rp_after got=%b/%h exp=1/0", M1_HREADY, S_HTRANS); end
        step(); #2;
        total++; if (S_HTRANS !== 2'b00 || M0_HREADY !== 1'b1) begin bad++; $display("FAIL rp_no_grant got=%h/%b exp=0/1", S_HTRANS, M0_HREADY); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESETn = 1'b0;
        S_HREADYOUT = 1'b1;
        m0(2'b10, 32'h10, 1'b0, 32'h0);
        m1(2'b00, 32'h0, 1'b0, 32'h0);
        test_reset();
        test_single_write();
        test_both_reads();
        test_burst_interleave();
        test_fixed_priority();
        test_stall();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
